mux_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4:1 datapath mux between four requesters and drives its 2-bit select.
- Grants one requester at a time for a burst of beats, with a valid/ready handshake to the downstream consumer.
- Enforces a burst limit for fairness.
- Sits between the CPU's four bus masters and the shared mux/consumer. The mux data path itself stays external.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mux_arbiter_rr_pick.sv | 30 +++
 rtl/mux_arbiter.sv | 105 ++++++++++
 tb/tb_mux_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared arbitration constants and the arbiter FSM state encoding.
package cpu_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set request
// at or above i_ptr, wrapping modulo NUM_REQ.
module rr_pick
  import cpu_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [SEL_W-1:0]   o_idx
);

  logic [SEL_W-1:0] w_cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_cand[gi] = i_ptr + SEL_W'(gi);
    end
  endgenerate

  // Scan from the farthest candidate back so the closest to i_ptr wins.
  always_comb begin
    o_found = |i_req;
    o_idx   = i_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[w_cand[i]]) o_idx = w_cand[i];
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin burst arbiter driving the shared 4:1 mux select.
// Optional MUX_ARBITER_LOCK_EN adds i_lock to suppress burst-limit release.
module mux_arbiter
  import cpu_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic [3:0] i_last,
  input  logic       i_ready,
`ifdef MUX_ARBITER_LOCK_EN
  input  logic [3:0] i_lock,
`endif
  output logic [1:0] o_sel,
  output logic [3:0] o_gnt,
  output logic       o_valid,
  output logic [3:0] o_ack,
  output logic       o_busy,
  output logic       o_preempt
);

  logic [0:0]         r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_REQ-1:0] r_gnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_ptr;
  logic               r_preempt;

  logic             w_found;
  logic [SEL_W-1:0] w_pick;
  logic             w_grant;
  logic             w_beat;
  logic             w_at_limit;
  logic             w_locked;
  logic             w_last_rel;
  logic             w_limit_rel;
  logic             w_release;

  rr_pick u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef MUX_ARBITER_LOCK_EN
  assign w_locked = i_lock[r_sel];
`else
  assign w_locked = 1'b0;
`endif

  assign w_grant     = (r_state == ARB_GRANT);
  assign o_valid     = w_grant & i_req[r_sel];
  assign w_beat      = o_valid & i_ready;
  assign o_ack       = w_beat ? r_gnt : '0;
  assign w_at_limit  = (r_cnt == CNT_W'(MAX_BURST - 1));
  assign w_last_rel  = w_beat & i_last[r_sel];
  assign w_limit_rel = w_beat & w_at_limit & ~w_locked;
  // A withdrawn request also drops o_valid, so no beat can accompany it.
  assign w_release   = w_last_rel | w_limit_rel | ~i_req[r_sel];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ARB_IDLE;
      r_sel     <= '0;
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_preempt <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_preempt <= 1'b0;
          if (w_found) begin
            r_state <= ARB_GRANT;
            r_sel   <= w_pick;
            r_gnt   <= sel_to_onehot(w_pick);
            r_cnt   <= '0;
          end
        end
        default: begin
          r_preempt <= w_limit_rel & ~w_last_rel;
          if (w_release) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_ptr   <= r_sel + 1'b1;
          end else if (w_beat && !w_at_limit) begin
            // Holding at the limit gives saturation while locked.
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_sel     = r_sel;
  assign o_gnt     = r_gnt;
  assign o_busy    = w_grant;
  assign o_preempt = r_preempt;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a behavioural burst model.
module tb_mux_arbiter;

  localparam int MAX_BURST = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] last = '0;
  logic       ready = 1'b0;
`ifdef MUX_ARBITER_LOCK_EN
  logic [3:0] lock = '0;
`endif
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic [3:0] ack;
  logic       busy;
  logic       preempt;

  int total = 0;
  int bad = 0;

  // Model: owner of the current burst (-1 when idle), beats so far, next start point.
  int m_owner = -1;
  int m_beats = 0;
  int m_next  = 0;
  int m_sel   = 0;
  bit m_pre   = 1'b0;

  always #5 clk = ~clk;

  mux_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(8)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_last    (last),
    .i_ready   (ready),
`ifdef MUX_ARBITER_LOCK_EN
    .i_lock    (lock),
`endif
    .o_sel     (sel),
    .o_gnt     (gnt),
    .o_valid   (valid),
    .o_ack     (ack),
    .o_busy    (busy),
    .o_preempt (preempt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] e_gnt;
    logic       e_valid;
    e_gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    e_valid = (m_owner >= 0) && req[m_owner];
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("ack", 32'(ack), (e_valid && ready) ? 32'(e_gnt) : 32'd0);
    chk("preempt", 32'(preempt), 32'(m_pre));
  endtask

  task automatic model_step();
    bit locked;
    locked = 1'b0;
    m_pre  = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < 4; i++) begin
        if (m_owner < 0 && req[(m_next + i) % 4]) begin
          m_owner = (m_next + i) % 4;
          m_sel   = m_owner;
          m_beats = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_next  = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (ready) begin
`ifdef MUX_ARBITER_LOCK_EN
      locked = lock[m_owner];
`endif
      m_beats++;
      if (last[m_owner]) begin
        m_next  = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (m_beats >= MAX_BURST && !locked) begin
        m_pre   = 1'b1;
        m_next  = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    @(negedge clk);
    req   = r;
    last  = l;
    ready = rdy;
    #1;
    compare_outputs();
    model_step();
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    #2;
    req   = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    m_owner = -1;
    m_beats = 0;
    m_next  = 0;
    m_sel   = 0;
    m_pre   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r_rand;
    #1;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_gnt", 32'(gnt), 32'd0);
    chk("init_sel", 32'(sel), 32'd0);
    chk("init_valid", 32'(valid), 32'd0);
    chk("init_ack", 32'(ack), 32'd0);
    chk("init_preempt", 32'(preempt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request, one-beat burst
    for (int i = 0; i < 4; i++) cycle(4'b0100, 4'b0100, 1'b1);
    // round-robin with single-beat bursts
    for (int i = 0; i < 12; i++) cycle(4'b1111, 4'b1111, 1'b1);
    // burst limit on a streaming requester, neighbour pending
    for (int i = 0; i < 14; i++) cycle(4'b0110, 4'b0000, 1'b1);
    // back-pressure
    for (int i = 0; i < 10; i++) cycle(4'b0001, 4'b0000, 1'(i % 2));
    cycle(4'b0001, 4'b0001, 1'b1);
    // withdraw mid-burst
    for (int i = 0; i < 4; i++) cycle(4'b0001, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    // reset while a grant is held
    for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0000, 1'b0);
    reset_mid_run();
    cycle(4'b0000, 4'b0000, 1'b0);

`ifdef MUX_ARBITER_LOCK_EN
    lock = 4'b1000;
    for (int i = 0; i < 22; i++) cycle(4'b1000, 4'b0000, 1'b1);
    cycle(4'b1000, 4'b1000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
`endif

    // randomized traffic with slowly changing requests
    r_rand = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) r_rand[b] = ~r_rand[b];
`ifdef MUX_ARBITER_LOCK_EN
      if ($urandom_range(0, 15) == 0) lock = 4'($urandom);
`endif
      cycle(r_rand, 4'($urandom) & 4'($urandom) & 4'($urandom),
            1'($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
